// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with byte-lane write enables and a self-clearing sequencer after reset.
// Latency: q/q_valid one cycle after the accepted access (two with OUT_REG=1); one access per cycle.
// No backpressure: accesses presented while busy is high are silently ignored.
module sp_ram_be #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  write_enable,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data,
  output logic [DATA_W-1:0]     q,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int                LANES   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W stays representable in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                in_range;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged;

  logic [DATA_W-1:0]   q1;
  logic                v1;
  logic                e1;

  // Decode the current access: range check, stored word and byte-merged write word.
  always_comb begin
    in_range = ({1'b0, address} < DEPTH_X);
    accept   = en && (state == S_READY);
    old_word = '0;
    if (in_range) begin
      old_word = mem[address];
    end
    merged = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  // Clear sequencer: walk every word once after reset, then open the RAM for accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (state == S_CLEAR) begin
      if (clr_cnt == LAST) begin
        state <= S_READY;
        busy  <= 1'b0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Storage: zero-fill while clearing, otherwise per-lane writes to in-range addresses only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (accept && write_enable && in_range) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) begin
            mem[address][8*i +: 8] <= data[8*i +: 8];
          end
        end
      end
    end
  end

  // First output stage: read data / read-during-write result, valid and range error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else begin
      v1 <= 1'b0;
      e1 <= 1'b0;
      if (accept) begin
        e1 <= !in_range;
        if (!write_enable) begin
          q1 <= old_word;
          v1 <= 1'b1;
        end else if (RDW_MODE == 0) begin
          q1 <= old_word;
          v1 <= 1'b1;
        end else if (RDW_MODE == 1) begin
          // Out-of-range writes store nothing, so the "post-write" word is zero.
          q1 <= in_range ? merged : '0;
          v1 <= 1'b1;
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      // Optional retiming stage: delays q, q_valid and addr_err together by one cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          q        <= '0;
          q_valid  <= 1'b0;
          addr_err <= 1'b0;
        end else begin
          q        <= q1;
          q_valid  <= v1;
          addr_err <= e1;
        end
      end
    end else begin : g_direct
      assign q        = q1;
      assign q_valid  = v1;
      assign addr_err = e1;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_be.sv
// Bench for sp_ram_be: five configurations driven by one shared stimulus stream.
// Each instance is compared every cycle against its own behavioural model.
// Directed scenarios come first, then a randomized phase with sporadic resets.
module tb_sp_ram_be;

  localparam int NI = 5;

  // Instance configurations: 0..2 = RDW modes, 3 = output register, 4 = shallow RAM.
  function automatic int dep_of(input int k);
    return (k == 4) ? 48 : 64;
  endfunction

  function automatic int mode_of(input int k);
    return (k <= 2) ? k : 0;
  endfunction

  function automatic int oreg_of(input int k);
    return (k == 3) ? 1 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [5:0]  addr = 6'd0;
  logic [31:0] dat = 32'd0;

  logic [31:0] q_w    [NI];
  logic        qv_w   [NI];
  logic        busy_w [NI];
  logic        err_w  [NI];

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      sp_ram_be #(
        .DATA_W   (32),
        .ADDR_W   (6),
        .DEPTH    (dep_of(k)),
        .RDW_MODE (mode_of(k)),
        .OUT_REG  (oreg_of(k))
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .write_enable (we),
        .be           (be),
        .address      (addr),
        .data         (dat),
        .q            (q_w[k]),
        .q_valid      (qv_w[k]),
        .busy         (busy_w[k]),
        .addr_err     (err_w[k])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: memory contents, remaining clear cycles, and the result of the
  // most recent and the previous edge (the latter is what an output register shows).
  logic [31:0] mm [NI][64];
  int          clr_left [NI];
  logic [31:0] r_q  [NI];
  logic        r_v  [NI];
  logic        r_e  [NI];
  logic [31:0] p_q  [NI];
  logic        p_v  [NI];
  logic        p_e  [NI];

  task automatic step(input bit r, input bit e, input bit w, input logic [3:0] b,
                      input logic [5:0] a, input logic [31:0] d);
    logic [31:0] oldw;
    logic [31:0] mask;
    logic [31:0] mrg;
    logic [31:0] xq;
    logic        xv;
    logic        xe;
    bit          inr;
    rst  = r;
    en   = e;
    we   = w;
    be   = b;
    addr = a;
    dat  = d;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (r) begin
        for (int i = 0; i < 64; i++) mm[k][i] = 32'd0;
        clr_left[k] = dep_of(k);
        r_q[k] = 32'd0; r_v[k] = 1'b0; r_e[k] = 1'b0;
        p_q[k] = 32'd0; p_v[k] = 1'b0; p_e[k] = 1'b0;
      end else begin
        p_q[k] = r_q[k]; p_v[k] = r_v[k]; p_e[k] = r_e[k];
        r_v[k] = 1'b0;
        r_e[k] = 1'b0;
        if (clr_left[k] > 0) begin
          clr_left[k]--;
        end else if (e) begin
          inr  = int'(a) < dep_of(k);
          oldw = inr ? mm[k][a] : 32'd0;
          mask = 32'd0;
          for (int i = 0; i < 4; i++) if (b[i]) mask = mask | (32'hFF << (8 * i));
          mrg  = (oldw & ~mask) | (d & mask);
          r_e[k] = !inr;
          if (!w) begin
            r_q[k] = oldw;
            r_v[k] = 1'b1;
          end else begin
            if (inr) mm[k][a] = mrg;
            if (mode_of(k) == 0) begin
              r_q[k] = oldw;
              r_v[k] = 1'b1;
            end else if (mode_of(k) == 1) begin
              r_q[k] = inr ? mrg : 32'd0;
              r_v[k] = 1'b1;
            end
          end
        end
      end
      xq = oreg_of(k) != 0 ? p_q[k] : r_q[k];
      xv = oreg_of(k) != 0 ? p_v[k] : r_v[k];
      xe = oreg_of(k) != 0 ? p_e[k] : r_e[k];
      check_val($sformatf("u%0d.q", k),        q_w[k],             xq);
      check_val($sformatf("u%0d.q_valid", k),  {31'd0, qv_w[k]},   {31'd0, xv});
      check_val($sformatf("u%0d.addr_err", k), {31'd0, err_w[k]},  {31'd0, xe});
      check_val($sformatf("u%0d.busy", k),     {31'd0, busy_w[k]}, {31'd0, clr_left[k] > 0});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 6'd0, 32'd0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b0, 1'b1, 1'b1, b, a, d);
  endtask

  task automatic rd(input logic [5:0] a);
    step(1'b0, 1'b1, 1'b0, 4'h0, a, 32'd0);
  endtask

  initial begin
    int n0;
    int n4;
    bit          rr;
    bit          re;
    bit          rw;
    logic [3:0]  rb;
    logic [5:0]  ra;
    logic [31:0] rdat;

    // Reset and clear duration.
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'd0);
    check_val("rst_busy",  {31'd0, busy_w[0]}, 32'd1);
    check_val("rst_q",     q_w[0],             32'd0);
    check_val("rst_valid", {31'd0, qv_w[0]},   32'd0);
    n0 = 1;
    n4 = 1;
    for (int i = 0; i < 100; i++) begin
      idle();
      if (busy_w[0]) n0++;
      if (busy_w[4]) n4++;
    end
    check_val("clear_len64", n0, 32'd64);
    check_val("clear_len48", n4, 32'd48);

    // Cleared contents read back as zero with a one-cycle valid pulse.
    rd(6'd0);  check_val("rd0_v", {31'd0, qv_w[0]}, 32'd1);  check_val("rd0_q", q_w[0], 32'd0);
    idle();    check_val("rd0_pulse", {31'd0, qv_w[0]}, 32'd0);
    rd(6'd31); check_val("rd31_v", {31'd0, qv_w[0]}, 32'd1); check_val("rd31_q", q_w[0], 32'd0);
    idle();
    rd(6'd63); check_val("rd63_v", {31'd0, qv_w[0]}, 32'd1); check_val("rd63_q", q_w[0], 32'd0);
    idle();

    // Byte-lane merge.
    wr(6'd5, 32'hDEADBEEF, 4'b1111);
    wr(6'd5, 32'h11223344, 4'b0101);
    rd(6'd5);
    check_val("be_merge", q_w[0], 32'hDE22BE44);

    // Read-during-write behaviour in the three modes.
    wr(6'd9, 32'hAAAAAAAA, 4'b1111);
    wr(6'd9, 32'h55555555, 4'b1111);
    check_val("rf_q", q_w[0], 32'hAAAAAAAA);
    check_val("rf_v", {31'd0, qv_w[0]}, 32'd1);
    check_val("wf_q", q_w[1], 32'h55555555);
    check_val("wf_v", {31'd0, qv_w[1]}, 32'd1);
    check_val("nc_q", q_w[2], 32'hDE22BE44);
    check_val("nc_v", {31'd0, qv_w[2]}, 32'd0);

    // Output register: back-to-back reads appear two cycles after the request.
    wr(6'd1, 32'd1, 4'hF);
    wr(6'd2, 32'd2, 4'hF);
    wr(6'd3, 32'd3, 4'hF);
    idle();
    idle();
    rd(6'd1); check_val("oreg_c1_v", {31'd0, qv_w[3]}, 32'd0);
    rd(6'd2); check_val("oreg_c2_v", {31'd0, qv_w[3]}, 32'd1); check_val("oreg_c2_q", q_w[3], 32'd1);
    rd(6'd3); check_val("oreg_c3_v", {31'd0, qv_w[3]}, 32'd1); check_val("oreg_c3_q", q_w[3], 32'd2);
    idle();   check_val("oreg_c4_v", {31'd0, qv_w[3]}, 32'd1); check_val("oreg_c4_q", q_w[3], 32'd3);
    idle();   check_val("oreg_c5_v", {31'd0, qv_w[3]}, 32'd0);

    // Out-of-range accesses on the 48-word instance.
    wr(6'd50, 32'hFFFFFFFF, 4'hF);
    check_val("oor_wr_err", {31'd0, err_w[4]}, 32'd1);
    check_val("oor_wr_v",   {31'd0, qv_w[4]},  32'd1);
    rd(6'd50);
    check_val("oor_rd_err", {31'd0, err_w[4]}, 32'd1);
    check_val("oor_rd_q",   q_w[4],            32'd0);
    rd(6'd47);
    check_val("last_err",   {31'd0, err_w[4]}, 32'd0);
    check_val("last_q",     q_w[4],            32'd0);
    idle();
    check_val("err_pulse",  {31'd0, err_w[4]}, 32'd0);

    // Reset in the middle of a clear restarts it from the beginning.
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'd0);
    for (int i = 0; i < 19; i++) begin
      if (i == 10) begin
        wr(6'd3, 32'hCAFEF00D, 4'hF);
        check_val("busy_wr_v", {31'd0, qv_w[0]}, 32'd0);
      end else begin
        idle();
      end
    end
    step(1'b1, 1'b0, 1'b0, 4'h0, 6'd0, 32'd0);
    n0 = 1;
    for (int i = 0; i < 100; i++) begin
      idle();
      if (busy_w[0]) n0++;
    end
    check_val("reclear_len", n0, 32'd64);
    rd(6'd3);
    check_val("reclear_q3", q_w[0], 32'd0);
    check_val("reclear_v3", {31'd0, qv_w[0]}, 32'd1);

    // Randomized traffic with occasional resets; addresses biased to collide.
    for (int i = 0; i < 3000; i++) begin
      rr   = ($urandom_range(0, 399) == 0);
      re   = ($urandom_range(0, 3) != 0);
      rw   = 1'($urandom_range(0, 1));
      rb   = 4'($urandom);
      ra   = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      rdat = $urandom;
      step(rr, re, rw, rb, ra, rdat);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
